// File: rtl/u_pkg.sv
// Shared types for the round-robin arbiter.
// Holds the arbiter FSM state encoding.
package u_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_t;

endpackage

// File: rtl/u_rr_pick.sv
// Round-robin pick: lowest set bit above the pivot, else the lowest set bit overall.
// Purely combinational; returns found flag, one-hot selection and its binary index.
module u_rr_pick #(
  parameter int W = 4,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  input  logic [IW-1:0] pivot,
  output logic          found,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic [W-1:0] hi_mask;
  logic [W-1:0] hi_vec;
  logic [W-1:0] sel;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_mask
      assign hi_mask[gi] = (32'(gi) > 32'(pivot));
    end
  endgenerate

  assign hi_vec = vec & hi_mask;
  assign sel    = (|hi_vec) ? hi_vec : vec;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot = sel & (~sel + W'(1));
  assign found  = |vec;

  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/u_rr_arb.sv
// Round-robin arbiter with registered grant and ready/valid handshake.
// The pointer advances only when a grant is accepted.
module u_rr_arb
  import u_pkg::*;
#(
  parameter int W = 4,
  localparam int IW = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic [W-1:0]  i_req,
  input  logic [W-1:0]  i_en,
  input  logic          i_gnt_rdy,
  output logic          o_gnt_vld,
  output logic [W-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  state_t        state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [W-1:0]  gnt_reg, gnt_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          vld_reg, vld_next;

  logic [W-1:0]  elig;
  logic [IW-1:0] pivot;
  logic          pick_found;
  logic [W-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;

  assign elig = i_req & i_en;

  u_rr_pick #(.W(W)) u_pick (
    .vec    (elig),
    .pivot  (pivot),
    .found  (pick_found),
    .onehot (pick_gnt),
    .idx    (pick_idx)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= IW'(W - 1);
      gnt_reg   <= '0;
      idx_reg   <= '0;
      vld_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
      vld_reg   <= vld_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    vld_next   = vld_reg;
    pivot      = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GNT;
          gnt_next   = pick_gnt;
          idx_next   = pick_idx;
          vld_next   = 1'b1;
        end
      end
      GNT: begin
        // On accept the following pick already sees the advanced pointer.
        if (i_gnt_rdy) begin
          ptr_next = idx_reg;
          pivot    = idx_reg;
          if (pick_found) begin
            gnt_next = pick_gnt;
            idx_next = pick_idx;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            idx_next   = '0;
            vld_next   = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_gnt_vld = vld_reg;
  assign o_gnt     = gnt_reg;
  assign o_gnt_idx = idx_reg;

endmodule

// File: tb/tb_u_rr_arb.sv
// Bench for u_rr_arb: directed vector table, reset corner cases, and random
// traffic checked against a rotating-priority reference model.
module tb_u_rr_arb;

  localparam int W  = 4;
  localparam int IW = 2;

  logic          i_clk = 1'b0;
  logic          i_arst_n = 1'b0;
  logic [W-1:0]  i_req = '0;
  logic [W-1:0]  i_en = '1;
  logic          i_gnt_rdy = 1'b0;
  logic          o_gnt_vld;
  logic [W-1:0]  o_gnt;
  logic [IW-1:0] o_gnt_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit m_vld;
  int m_idx;
  int m_ptr;

  typedef struct {
    logic [W-1:0]  req;
    logic [W-1:0]  en;
    logic          rdy;
    logic          vld;
    logic [W-1:0]  gnt;
    logic [IW-1:0] idx;
  } vec_t;

  vec_t tbl[20];

  u_rr_arb #(.W(W)) dut (
    .i_clk     (i_clk),
    .i_arst_n  (i_arst_n),
    .i_req     (i_req),
    .i_en      (i_en),
    .i_gnt_rdy (i_gnt_rdy),
    .o_gnt_vld (o_gnt_vld),
    .o_gnt     (o_gnt),
    .o_gnt_idx (o_gnt_idx)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // First eligible index scanning ptr+1, ptr+2, ... modulo W; -1 if none.
  function automatic int ref_pick(input logic [W-1:0] e, input int p);
    for (int k = 1; k <= W; k++) begin
      int j;
      j = (p + k) % W;
      if (e[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [W-1:0] req, input logic [W-1:0] en, input logic rdy);
    int j;
    if (m_vld && !rdy) return;
    if (m_vld && rdy) m_ptr = m_idx;
    j = ref_pick(req & en, m_ptr);
    if (j >= 0) begin
      m_vld = 1'b1;
      m_idx = j;
    end else begin
      m_vld = 1'b0;
      m_idx = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    int exp_gnt;
    exp_gnt = m_vld ? (1 << m_idx) : 0;
    chk({tag, ".vld"}, int'(o_gnt_vld), int'(m_vld));
    chk({tag, ".gnt"}, int'(o_gnt), exp_gnt);
    chk({tag, ".idx"}, int'(o_gnt_idx), m_vld ? m_idx : 0);
    chk({tag, ".onehot"}, int'($countones(o_gnt) <= 1), 1);
  endtask

  // Drive at negedge, let the DUT and model take the edge, sample at next negedge.
  task automatic step(input string tag, input logic [W-1:0] req, input logic [W-1:0] en, input logic rdy);
    i_req = req;
    i_en = en;
    i_gnt_rdy = rdy;
    @(posedge i_clk);
    model_edge(req, en, rdy);
    @(negedge i_clk);
    check_outputs(tag);
    $display("%s req=%b en=%b rdy=%b -> vld=%b gnt=%b idx=%0d", tag, req, en, rdy,
             o_gnt_vld, o_gnt, o_gnt_idx);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #2 i_arst_n = 1'b0;
    #1;
    chk("rst.vld", int'(o_gnt_vld), 0);
    chk("rst.gnt", int'(o_gnt), 0);
    chk("rst.idx", int'(o_gnt_idx), 0);
    m_vld = 1'b0;
    m_idx = 0;
    m_ptr = W - 1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_arst_n = 1'b1;
    $display("reset vld=%b gnt=%b idx=%0d", o_gnt_vld, o_gnt, o_gnt_idx);
  endtask

  initial begin
    // rotation from reset
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
    tbl[5]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0};
    // stall holds the grant, even after the request drops
    tbl[6]  = '{4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1};
    tbl[7]  = '{4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1};
    tbl[8]  = '{4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1};
    tbl[9]  = '{4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1};
    tbl[10] = '{4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1};
    tbl[11] = '{4'b0100, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1};
    tbl[12] = '{4'b0100, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2};
    // wrap-around after index 2
    tbl[13] = '{4'b0011, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
    tbl[14] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0};
    // masked requester never granted until enabled
    tbl[15] = '{4'b0100, 4'b1011, 1'b1, 1'b0, 4'b0000, 2'd0};
    tbl[16] = '{4'b0100, 4'b1011, 1'b1, 1'b0, 4'b0000, 2'd0};
    tbl[17] = '{4'b0100, 4'b1011, 1'b0, 1'b0, 4'b0000, 2'd0};
    tbl[18] = '{4'b0100, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2};
    tbl[19] = '{4'b0100, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2};

    do_reset();

    for (int i = 0; i < 20; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].req, tbl[i].en, tbl[i].rdy);
      chk($sformatf("tbl%0d.vld", i), int'(o_gnt_vld), int'(tbl[i].vld));
      chk($sformatf("tbl%0d.gnt", i), int'(o_gnt), int'(tbl[i].gnt));
      chk($sformatf("tbl%0d.idx", i), int'(o_gnt_idx), int'(tbl[i].idx));
    end

    // reset in the middle of a held grant, then restart from requester 0
    do_reset();
    step("rst_resume", 4'b1111, 4'b1111, 1'b1);
    chk("rst_resume.gnt", int'(o_gnt), 4'b0001);

    // sole requester regranted every cycle
    for (int i = 0; i < 5; i++) begin
      step($sformatf("sole%0d", i), 4'b1000, 4'b1111, 1'b1);
      chk($sformatf("sole%0d.gnt", i), int'(o_gnt), 4'b1000);
      chk($sformatf("sole%0d.idx", i), int'(o_gnt_idx), 3);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] r, e;
      logic         y;
      if (i == 200) do_reset();
      r = W'($urandom_range(0, 15));
      e = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 15)) : 4'b1111;
      y = 1'($urandom_range(0, 1));
      step($sformatf("rnd%0d", i), r, e, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
